game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Run-state sequencer for the snake datapath (head, body FIFO, occupancy map, apple gen).
//  Owns the game FSM (idle/run/pause/over), the step strobe that advances the datapath,
//    and the direction register fed from a 2-deep turn queue.
//  Counts score and speed level; shortens the step period as the level rises.
//  Sits in top between the synchronized buttons and the datapath. Runs on pix_clk.
// PARAMETERS
//  CLK_FREQ          25_000_000  clk rate in Hz
//  BASE_TPS          6           steps/s at level 0; PERIOD0 = CLK_FREQ/BASE_TPS (elaboration-time)
//  LEVEL_DEC         200_000     clocks removed from the period per level
//  MIN_PERIOD        1_000_000   period floor in clocks
//  APPLES_PER_LEVEL  4           apples eaten per level increment
//  MAX_LEVEL         15          level saturation value
//  SCORE_W           8           score width; score saturates at 2^SCORE_W-1
// PORTS
//  clk        in   1        clock (pix_clk domain)
//  reset_n    in   1        asynchronous, active-low reset
//  btn_start  in   1        start/pause button, already synchronized, level
//  btn_u/d/l/r in  1 each   direction buttons, already synchronized, level
//  ate_evt    in   1        1-cycle pulse from datapath: the step just taken ate the apple
//  hit_evt    in   1        1-cycle pulse from datapath: the step just taken is a self-collision
//  step       out  1        1-cycle pulse; datapath advances one cell
//  clear      out  1        1-cycle pulse; datapath re-initialises (body, map, head, apple)
//  dir        out  2        00 up, 01 right, 10 down, 11 left; stable when step=1
//  state      out  2        00 IDLE/CLEAR, 01 RUN, 10 PAUSE, 11 OVER
//  score      out  SCORE_W  apples eaten this game
//  level      out  4        current speed level
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, step=0, clear=0, dir=01, score=0, level=0,
//    apple_cnt=0, queue empty, period counter=0. Previous-button registers reset to 1,
//    so buttons held through reset generate no edge.
//  Edges: rising edge = btn & ~btn_prev, evaluated every cycle.
//  FSM: IDLE --start edge--> CLEAR (1 cycle, clear=1) --> RUN.
//    RUN --start edge--> PAUSE. PAUSE --start edge--> RUN. RUN --hit_evt--> OVER.
//    OVER --start edge--> CLEAR. hit_evt/ate_evt are ignored outside RUN.
//  In CLEAR: score, level and apple_cnt go to 0, dir goes to 01, the queue is flushed,
//    and the period counter is loaded with period(0).
//  Period: period(L) = max(PERIOD0 - L*LEVEL_DEC, MIN_PERIOD).
//    In RUN the counter decrements each cycle. At 1 it pops the queue into dir
//    (if not empty) and reloads period(level); step=1 on the next cycle.
//    Step spacing is exactly period(level) clocks.
//    In PAUSE the counter and queue are frozen and turn edges are dropped.
//  Turn queue: 2 entries, accepted only in RUN. One edge per cycle, priority U>D>L>R.
//    The reference direction is the last queued entry, or dir if the queue is empty.
//    Reject a turn that is the reference or its reverse (180 degrees).
//    Drop the turn when the queue is full.
//    Pop and push in the same cycle: pop first, then validate against the post-pop reference.
//  ate_evt in RUN: score+1 (saturating) and apple_cnt+1. When apple_cnt reaches
//    APPLES_PER_LEVEL: apple_cnt=0 and level+1 (saturating at MAX_LEVEL).
//    The new level applies from the next reload.
//  ate_evt and hit_evt in the same cycle: hit wins, go to OVER, score unchanged.
//  Step that would fire in the cycle of a pause edge: suppressed, counter held at 1.
//  Reset mid-game: immediate return to IDLE with the reset values above; no clear pulse.
// TESTING (CLK_FREQ=100, BASE_TPS=10 -> PERIOD0=10, LEVEL_DEC=2, MIN_PERIOD=4, APPLES_PER_LEVEL=2)
//  Release reset, start edge -> clear=1 for exactly 1 cycle, state 01;
//    first step 10 clks after CLEAR, then every 10 clks, dir=01.
//  In RUN press L (reverse of right) -> dropped, dir stays 01.
//    Press U then L within one period -> next two steps carry dir 00 then 11.
//  Press U, R, D in one period -> U and R queued, D dropped (queue full).
//  Pulse ate_evt 2x -> score=2, level=1, step spacing becomes 8.
//    After 6 more apples -> level=4, spacing clamps to 4.
//  Pause in RUN, wait 50 clks -> no step, turn edges ignored.
//    Resume -> the remaining count continues; the next step arrives after the frozen remainder.
//  ate_evt with hit_evt in the same cycle -> state=11, score unchanged.
//    Start edge -> clear pulse, score=0, level=0; assert reset_n=0 mid-RUN -> all outputs at reset values.

Source files
------------

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - buttons, datapath events and run-state outputs of the snake sequencer
interface game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               btn_start;
  logic               btn_u;
  logic               btn_d;
  logic               btn_l;
  logic               btn_r;
  logic               ate_evt;
  logic               hit_evt;
  logic               step;
  logic               clear;
  logic [1:0]         dir;
  logic [1:0]         state;
  logic [SCORE_W-1:0] score;
  logic [3:0]         level;

  modport master (
    input  btn_start, btn_u, btn_d, btn_l, btn_r, ate_evt, hit_evt,
    output step, clear, dir, state, score, level
  );

  modport slave (
    output btn_start, btn_u, btn_d, btn_l, btn_r, ate_evt, hit_evt,
    input  step, clear, dir, state, score, level
  );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - snake run-state FSM, step timer, turn queue, score and level
module game_ctrl #(
  parameter int CLK_FREQ         = 25_000_000,
  parameter int BASE_TPS         = 6,
  parameter int LEVEL_DEC        = 200_000,
  parameter int MIN_PERIOD       = 1_000_000,
  parameter int APPLES_PER_LEVEL = 4,
  parameter int MAX_LEVEL        = 15,
  parameter int SCORE_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  game_ctrl_if.master bus
);
  localparam int PERIOD0 = CLK_FREQ / BASE_TPS;
  localparam int CNT_W   = $clog2(PERIOD0 + 1);
  localparam int AC_W    = $clog2(APPLES_PER_LEVEL + 1);

  // Low two bits are the externally visible state code; CLEAR reads as IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_CLEAR = 3'b100,
    S_RUN   = 3'b001,
    S_PAUSE = 3'b010,
    S_OVER  = 3'b011
  } state_t;

  state_t             st;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         dir_r;
  logic [1:0]         q [2];
  logic [1:0]         q_cnt;
  logic [AC_W-1:0]    apple_cnt;
  logic [3:0]         level_r;
  logic [SCORE_W-1:0] score_r;
  logic               step_r;
  logic               clear_r;
  logic               start_prev, u_prev, d_prev, l_prev, r_prev;

  logic               start_edge;
  logic               turn_vld;
  logic [1:0]         turn;
  logic               fire;
  logic               pop;
  logic               push;
  logic [1:0]         post_cnt;
  logic [1:0]         post_dir;
  logic [1:0]         ref_dir;
  logic [31:0]        dec;
  logic [CNT_W-1:0]   reload;

  assign start_edge = bus.btn_start & ~start_prev;

  always_comb begin
    dec = 32'(level_r) * 32'(LEVEL_DEC);
    if (32'(PERIOD0) < 32'(MIN_PERIOD) + dec) reload = CNT_W'(MIN_PERIOD);
    else                                      reload = CNT_W'(32'(PERIOD0) - dec);
  end

  // Turn validation sees the queue as it will be after this cycle's pop.
  always_comb begin
    turn_vld = 1'b1;
    turn     = 2'b00;
    if      (bus.btn_u & ~u_prev) turn = 2'b00;
    else if (bus.btn_d & ~d_prev) turn = 2'b10;
    else if (bus.btn_l & ~l_prev) turn = 2'b11;
    else if (bus.btn_r & ~r_prev) turn = 2'b01;
    else                          turn_vld = 1'b0;

    fire     = (cnt == CNT_W'(1)) && !start_edge && !bus.hit_evt;
    pop      = fire && (q_cnt != 2'd0);
    post_cnt = pop ? q_cnt - 2'd1 : q_cnt;
    post_dir = pop ? q[0] : dir_r;
    if (post_cnt == 2'd0)      ref_dir = post_dir;
    else if (post_cnt == 2'd1) ref_dir = pop ? q[1] : q[0];
    else                       ref_dir = q[1];
    push = turn_vld && (post_cnt != 2'd2) && (turn != ref_dir) && (turn != (ref_dir ^ 2'b10));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= S_IDLE;
      cnt        <= '0;
      dir_r      <= 2'b01;
      q[0]       <= 2'b00;
      q[1]       <= 2'b00;
      q_cnt      <= 2'd0;
      apple_cnt  <= '0;
      level_r    <= 4'd0;
      score_r    <= '0;
      step_r     <= 1'b0;
      clear_r    <= 1'b0;
      start_prev <= 1'b1;
      u_prev     <= 1'b1;
      d_prev     <= 1'b1;
      l_prev     <= 1'b1;
      r_prev     <= 1'b1;
    end else begin
      start_prev <= bus.btn_start;
      u_prev     <= bus.btn_u;
      d_prev     <= bus.btn_d;
      l_prev     <= bus.btn_l;
      r_prev     <= bus.btn_r;
      step_r     <= 1'b0;
      clear_r    <= 1'b0;

      case (st)
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            st      <= S_CLEAR;
            clear_r <= 1'b1;
          end
        end
        S_CLEAR: begin
          st        <= S_RUN;
          score_r   <= '0;
          level_r   <= 4'd0;
          apple_cnt <= '0;
          dir_r     <= 2'b01;
          q_cnt     <= 2'd0;
          cnt       <= CNT_W'(PERIOD0);
        end
        S_RUN: begin
          if (bus.hit_evt) begin
            st <= S_OVER;
          end else begin
            if (start_edge) st <= S_PAUSE;
            if (bus.ate_evt) begin
              if (score_r != '1) score_r <= score_r + 1'b1;
              if (apple_cnt + 1'b1 == AC_W'(APPLES_PER_LEVEL)) begin
                apple_cnt <= '0;
                if (level_r != 4'(MAX_LEVEL)) level_r <= level_r + 4'd1;
              end else begin
                apple_cnt <= apple_cnt + 1'b1;
              end
            end
            // A pause edge landing on the firing cycle parks the counter at 1.
            if (fire) begin
              cnt    <= reload;
              step_r <= 1'b1;
            end else if (cnt != CNT_W'(1)) begin
              cnt <= cnt - CNT_W'(1);
            end
            if (pop) begin
              dir_r <= q[0];
              q[0]  <= q[1];
            end
            if (push) q[post_cnt[0]] <= turn;
            q_cnt <= post_cnt + {1'b0, push};
          end
        end
        S_PAUSE: begin
          if (start_edge) st <= S_RUN;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.step  = step_r;
  assign bus.clear = clear_r;
  assign bus.dir   = dir_r;
  assign bus.state = st[1:0];
  assign bus.score = score_r;
  assign bus.level = level_r;
endmodule
